// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
// Request/response bundle for alu_exec_unit.
//   iValid / oReady      : request handshake (requester -> unit / unit -> requester)
//   iOp, iA, iB          : opcode and operands, sampled when the request is accepted
//   oValid / iReady      : result handshake (unit -> consumer / consumer -> unit)
//   oResult, oResultHi   : result low half, high half (MUL only, else 0)
//   oFlags               : {N, Z, C, V}
// Modports: master = requester/consumer side, slave = the execution unit.
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic             iValid;
  logic             oReady;
  logic [3:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oResult;
  logic [WIDTH-1:0] oResultHi;
  logic [3:0]       oFlags;

  modport master (
    output iValid, iOp, iA, iB, iReady,
    input  oReady, oValid, oResult, oResultHi, oFlags
  );

  modport slave (
    input  iValid, iOp, iA, iB, iReady,
    output oReady, oValid, oResult, oResultHi, oFlags
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Single-request integer execution unit: ADD, SUB, AND, OR, XOR, SHL, SHR and
// an unsigned full-width MUL. One request is in flight at a time; the unit
// walks IDLE -> (BUSY) -> DONE -> IDLE.
//
// Parameters
//   WIDTH    : operand/result width (8..32, power of two)
//   FAST_MUL : 0 = iterative shift-add multiplier (WIDTH cycles),
//              1 = single-cycle multiplier
// Ports
//   Clock    : rising-edge clock for all state
//   Reset_n  : asynchronous active-low reset
//   bus      : alu_exec_unit_if.slave (request, result and flags)
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH    = 16,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic          Clock,
  input  logic          Reset_n,
  alu_exec_unit_if.slave bus
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // Two's-complement overflow of a sign-extended WIDTH+1 result: the extra
  // sign bit disagrees with the result's sign bit.
  function automatic logic signedOvf(input logic signed [WIDTH:0] s);
    return s[WIDTH] ^ s[WIDTH-1];
  endfunction

  // Flag packing {N, Z, C, V}; N and Z always follow the low result half.
  function automatic logic [3:0] mkFlags(input logic [WIDTH-1:0] r,
                                         input logic             c,
                                         input logic             v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  logic [1:0]         state;
  logic [WIDTH-1:0]   mulCand;
  logic [2*WIDTH-1:0] mulAcc;
  logic [CNT_W-1:0]   mulCnt;

  logic               accept;
  logic               iterMul;

  logic [WIDTH:0]          addU;
  logic [WIDTH:0]          subU;
  logic signed [WIDTH:0]   addS;
  logic signed [WIDTH:0]   subS;
  logic [SH_W-1:0]         shAmt;
  logic [2*WIDTH-1:0]      shlW;
  logic [2*WIDTH-1:0]      shrW;
  logic [2*WIDTH-1:0]      prod;

  logic [WIDTH-1:0]   nxtLo;
  logic [WIDTH-1:0]   nxtHi;
  logic [3:0]         nxtFlags;

  logic [WIDTH:0]     stepSum;
  logic [2*WIDTH-1:0] stepAcc;
  logic               lastStep;

  assign accept  = (state == IDLE) && bus.iValid && bus.oReady;
  assign iterMul = (bus.iOp == OP_MUL) && (FAST_MUL == 1'b0);

  // Single-cycle datapath, evaluated on the live request so the accept edge
  // captures the finished result directly.
  assign addU  = {1'b0, bus.iA} + {1'b0, bus.iB};
  assign subU  = {1'b0, bus.iA} - {1'b0, bus.iB};
  assign addS  = $signed({bus.iA[WIDTH-1], bus.iA}) + $signed({bus.iB[WIDTH-1], bus.iB});
  assign subS  = $signed({bus.iA[WIDTH-1], bus.iA}) - $signed({bus.iB[WIDTH-1], bus.iB});
  assign shAmt = bus.iB[SH_W-1:0];
  // Shifting inside a double-width word leaves the last bit shifted out at
  // bit WIDTH (left) or WIDTH-1 (right); it is 0 naturally for amount 0.
  assign shlW  = {{WIDTH{1'b0}}, bus.iA} << shAmt;
  assign shrW  = {bus.iA, {WIDTH{1'b0}}} >> shAmt;
  assign prod  = {{WIDTH{1'b0}}, bus.iA} * {{WIDTH{1'b0}}, bus.iB};

  always_comb begin
    nxtLo    = '0;
    nxtHi    = '0;
    nxtFlags = '0;
    case (bus.iOp)
      OP_ADD: begin
        nxtLo    = addU[WIDTH-1:0];
        nxtFlags = mkFlags(addU[WIDTH-1:0], addU[WIDTH], signedOvf(addS));
      end
      OP_SUB: begin
        // Bit WIDTH of the zero-extended difference is the borrow (A < B).
        nxtLo    = subU[WIDTH-1:0];
        nxtFlags = mkFlags(subU[WIDTH-1:0], subU[WIDTH], signedOvf(subS));
      end
      OP_AND: begin
        nxtLo    = bus.iA & bus.iB;
        nxtFlags = mkFlags(bus.iA & bus.iB, 1'b0, 1'b0);
      end
      OP_OR: begin
        nxtLo    = bus.iA | bus.iB;
        nxtFlags = mkFlags(bus.iA | bus.iB, 1'b0, 1'b0);
      end
      OP_XOR: begin
        nxtLo    = bus.iA ^ bus.iB;
        nxtFlags = mkFlags(bus.iA ^ bus.iB, 1'b0, 1'b0);
      end
      OP_SHL: begin
        nxtLo    = shlW[WIDTH-1:0];
        nxtFlags = mkFlags(shlW[WIDTH-1:0], shlW[WIDTH], 1'b0);
      end
      OP_SHR: begin
        nxtLo    = shrW[2*WIDTH-1:WIDTH];
        nxtFlags = mkFlags(shrW[2*WIDTH-1:WIDTH], shrW[WIDTH-1], 1'b0);
      end
      OP_MUL: begin
        nxtLo    = prod[WIDTH-1:0];
        nxtHi    = prod[2*WIDTH-1:WIDTH];
        nxtFlags = mkFlags(prod[WIDTH-1:0], |prod[2*WIDTH-1:WIDTH], 1'b0);
      end
      default: begin
        nxtLo    = '0;
        nxtHi    = '0;
        nxtFlags = '0;
      end
    endcase
  end

  // Iterative multiplier step: accumulator is {partial high, remaining
  // multiplier bits}. Add the multiplicand into the high half when the
  // current multiplier LSB is set, then shift the whole word right by one.
  assign stepSum  = {1'b0, mulAcc[2*WIDTH-1:WIDTH]} +
                    (mulAcc[0] ? {1'b0, mulCand} : {(WIDTH+1){1'b0}});
  assign stepAcc  = {stepSum, mulAcc[WIDTH-1:1]};
  assign lastStep = (mulCnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      bus.oReady    <= 1'b0;
      bus.oValid    <= 1'b0;
      bus.oResult   <= '0;
      bus.oResultHi <= '0;
      bus.oFlags    <= '0;
      mulCand       <= '0;
      mulAcc        <= '0;
      mulCnt        <= '0;
    end else begin
      case (state)
        // IDLE: ready is re-asserted every cycle we stay here, which also
        // raises it on the first edge after reset release.
        IDLE: begin
          if (accept) begin
            bus.oReady <= 1'b0;
            if (iterMul) begin
              state   <= BUSY;
              mulCand <= bus.iA;
              mulAcc  <= {{WIDTH{1'b0}}, bus.iB};
              mulCnt  <= '0;
            end else begin
              state         <= DONE;
              bus.oValid    <= 1'b1;
              bus.oResult   <= nxtLo;
              bus.oResultHi <= nxtHi;
              bus.oFlags    <= nxtFlags;
            end
          end else begin
            bus.oReady <= 1'b1;
          end
        end

        // BUSY: one shift-add step per cycle; the final step publishes the
        // product in the same edge.
        BUSY: begin
          mulAcc <= stepAcc;
          mulCnt <= mulCnt + 1'b1;
          if (lastStep) begin
            state         <= DONE;
            bus.oValid    <= 1'b1;
            bus.oResult   <= stepAcc[WIDTH-1:0];
            bus.oResultHi <= stepAcc[2*WIDTH-1:WIDTH];
            bus.oFlags    <= mkFlags(stepAcc[WIDTH-1:0],
                                     |stepAcc[2*WIDTH-1:WIDTH], 1'b0);
          end
        end

        // DONE: results are frozen until the consumer takes them.
        DONE: begin
          if (bus.iReady) begin
            state      <= IDLE;
            bus.oValid <= 1'b0;
            bus.oReady <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          bus.oValid <= 1'b0;
          bus.oReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int W = 16;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clock = ~Clock;

  alu_exec_unit_if #(.WIDTH(W)) slowBus ();
  alu_exec_unit_if #(.WIDTH(W)) fastBus ();

  alu_exec_unit #(.WIDTH(W), .FAST_MUL(1'b0)) uSlow (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (slowBus.slave)
  );

  alu_exec_unit #(.WIDTH(W), .FAST_MUL(1'b1)) uFast (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (fastBus.slave)
  );

  logic         useFast;
  logic         tbValid;
  logic         tbReady;
  logic [3:0]   tbOp;
  logic [W-1:0] tbA;
  logic [W-1:0] tbB;

  assign slowBus.iValid = tbValid & ~useFast;
  assign fastBus.iValid = tbValid & useFast;
  assign slowBus.iOp    = tbOp;
  assign fastBus.iOp    = tbOp;
  assign slowBus.iA     = tbA;
  assign fastBus.iA     = tbA;
  assign slowBus.iB     = tbB;
  assign fastBus.iB     = tbB;
  assign slowBus.iReady = tbReady;
  assign fastBus.iReady = tbReady;

  logic         selValid;
  logic         selReady;
  logic [W-1:0] selRes;
  logic [W-1:0] selHi;
  logic [3:0]   selFlags;

  assign selValid = useFast ? fastBus.oValid    : slowBus.oValid;
  assign selReady = useFast ? fastBus.oReady    : slowBus.oReady;
  assign selRes   = useFast ? fastBus.oResult   : slowBus.oResult;
  assign selHi    = useFast ? fastBus.oResultHi : slowBus.oResultHi;
  assign selFlags = useFast ? fastBus.oFlags    : slowBus.oFlags;

  int checks   = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural reference: {hi[15:0], lo[15:0], N, Z, C, V} from plain integer arithmetic.
  function automatic logic [35:0] refModel(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    longint ua, ub, sa, sb, r;
    int amt;
    logic [15:0] res, hi;
    logic c, v;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    amt = int'(b) % 16;
    res = 16'h0; hi = 16'h0; c = 1'b0; v = 1'b0; r = 0;
    case (op)
      4'd1: begin
        r = ua + ub; res = r[15:0]; c = (r > 65535);
        v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      4'd2: begin
        r = ua - ub; res = r[15:0]; c = (ua < ub);
        v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      4'd3: res = a & b;
      4'd4: res = a | b;
      4'd5: res = a ^ b;
      4'd6: begin
        r = ua << amt; res = r[15:0];
        c = (amt != 0) && (((ua >> (16 - amt)) & 1) == 1);
      end
      4'd7: begin
        r = ua >> amt; res = r[15:0];
        c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1);
      end
      4'd8: begin
        r = ua * ub; res = r[15:0]; hi = r[31:16]; c = (hi != 16'h0);
      end
      default: return 36'h0;
    endcase
    return {hi, res, res[15], (res == 16'h0), c, v};
  endfunction

  function automatic logic [15:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One full transaction: present, accept, wait for result, optional
  // backpressure with ignored iValid pulses, then handshake.
  task automatic runOp(input bit fast, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int holdCycles, input string tag);
    logic [35:0] exp;
    int lat, expLat, n;
    bit readyLow;
    exp     = refModel(op, a, b);
    expLat  = (op == 4'd8 && !fast) ? 17 : 1;
    useFast = fast;
    n = 0;
    while (!selReady && n < 50) begin
      @(posedge Clock); #1; n++;
    end
    checkVal({tag, " ready"}, 64'(selReady), 64'd1);
    if (!selReady) return;
    tbOp = op; tbA = a; tbB = b; tbValid = 1'b1;
    @(posedge Clock); #1;
    tbValid = 1'b0;
    tbOp = 4'($urandom); tbA = 16'($urandom); tbB = 16'($urandom);
    lat = 1; readyLow = 1'b1;
    while (!selValid && lat < 100) begin
      if (selReady) readyLow = 1'b0;
      @(posedge Clock); #1; lat++;
    end
    if (selReady) readyLow = 1'b0;
    checkVal({tag, " lat"}, 64'(lat), 64'(expLat));
    checkVal({tag, " rdyLow"}, 64'(readyLow), 64'd1);
    checkVal({tag, " out"}, {28'h0, selHi, selRes, selFlags}, {28'h0, exp});
    for (int i = 0; i < holdCycles; i++) begin
      if (i == 1) begin
        tbValid = 1'b1; tbOp = 4'd1; tbA = 16'($urandom); tbB = 16'($urandom);
      end else begin
        tbValid = 1'b0;
      end
      @(posedge Clock); #1;
      checkVal({tag, " hold"}, {26'h0, selValid, selReady, selHi, selRes, selFlags},
               {26'h0, 2'b10, exp});
    end
    tbValid = 1'b0;
    tbReady = 1'b1;
    @(posedge Clock); #1;
    tbReady = 1'b0;
    checkVal({tag, " hs"}, {62'h0, selValid, selReady}, 64'b01);
    @(posedge Clock); #1;
    checkVal({tag, " noQueue"}, {62'h0, selValid, selReady}, 64'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sawValid;
    useFast = 1'b0; tbValid = 1'b0; tbReady = 1'b0;
    tbOp = 4'h0; tbA = '0; tbB = '0;

    // Reset state and release behaviour
    #2 Reset_n = 1'b0;
    #1;
    checkVal("rstSlow", {21'h0, slowBus.oReady, slowBus.oValid, slowBus.oResult,
                         slowBus.oResultHi, slowBus.oFlags}, 64'h0);
    checkVal("rstFast", {21'h0, fastBus.oReady, fastBus.oValid, fastBus.oResult,
                         fastBus.oResultHi, fastBus.oFlags}, 64'h0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    checkVal("rdyBeforeEdge", {62'h0, slowBus.oReady, fastBus.oReady}, 64'b00);
    @(posedge Clock); #1;
    checkVal("rdyAfterRel", {62'h0, slowBus.oReady, fastBus.oReady}, 64'b11);

    // Directed cases
    runOp(1'b0, 4'd1, 16'h7FFF, 16'h0001, 0, "addOvf");
    runOp(1'b0, 4'd2, 16'h0003, 16'h0005, 0, "subBorrow");
    runOp(1'b0, 4'd2, 16'h8000, 16'h0001, 1, "subOvf");
    runOp(1'b0, 4'd8, 16'h1234, 16'h0100, 0, "mulIter");
    runOp(1'b1, 4'd8, 16'hFFFF, 16'hFFFF, 0, "mulFast");
    runOp(1'b0, 4'd8, 16'hFFFF, 16'hFFFF, 2, "mulIterMax");
    runOp(1'b0, 4'd5, 16'hAAAA, 16'hAAAA, 5, "xorBp");
    runOp(1'b0, 4'd6, 16'h8001, 16'h0000, 0, "shlZero");
    runOp(1'b0, 4'd6, 16'h8001, 16'h0001, 0, "shl1");
    runOp(1'b1, 4'd7, 16'h8001, 16'h000F, 0, "shr15");
    runOp(1'b1, 4'd7, 16'h0003, 16'h0011, 0, "shrAmtMask");
    runOp(1'b0, 4'd0, 16'h1234, 16'h5678, 0, "nop");
    runOp(1'b1, 4'd12, 16'hFFFF, 16'hFFFF, 0, "reserved");

    // Reset in the middle of an iterative MUL
    useFast = 1'b0;
    tbOp = 4'd8; tbA = 16'h1234; tbB = 16'h0100; tbValid = 1'b1;
    @(posedge Clock); #1;
    tbValid = 1'b0;
    repeat (7) @(posedge Clock);
    #1;
    checkVal("rstMidBusy", {62'h0, slowBus.oValid, slowBus.oReady}, 64'b00);
    Reset_n = 1'b0;
    #1;
    checkVal("rstMidAsync", {21'h0, slowBus.oReady, slowBus.oValid, slowBus.oResult,
                             slowBus.oResultHi, slowBus.oFlags}, 64'h0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    checkVal("rstMidRdy", {62'h0, slowBus.oValid, slowBus.oReady}, 64'b01);
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock); #1;
      if (slowBus.oValid) sawValid = 1'b1;
    end
    checkVal("rstMidNoValid", 64'(sawValid), 64'd0);
    runOp(1'b0, 4'd1, 16'h0002, 16'h0003, 0, "addAfterRst");

    // Randomized traffic across both multiplier variants
    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      runOp(1'($urandom_range(0, 1)), op, pickVal(), pickVal(), $urandom_range(0, 3),
            $sformatf("rnd%0d_op%0d", k, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 8..32, power of two).
REQ-002 SHALL have parameter FAST_MUL, default 0, where 0 selects the iterative shift-add multiplier and 1 selects the single-cycle multiplier.
REQ-003 SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset; one clock, no other clock domains.
REQ-005 SHALL have port iValid  input  1  request valid.
REQ-006 SHALL have port oReady  output  1  unit can accept a request.
REQ-007 SHALL have port iOp  input  4  opcode.
REQ-008 SHALL have ports iA, iB  input  WIDTH  operands.
REQ-009 SHALL have port oValid  output  1  result valid.
REQ-010 SHALL have port iReady  input  1  consumer accepts the result.
REQ-011 SHALL have port oResult  output  WIDTH  result, low half.
REQ-012 SHALL have port oResultHi  output  WIDTH  high half of the MUL product, 0 for all other ops.
REQ-013 SHALL have port oFlags  output  4  {N,Z,C,V}.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE; oReady is 1 only in IDLE and oValid is 1 only in DONE, both registered.
REQ-015 SHALL accept a request on a rising edge with iValid&&oReady and capture iOp/iA/iB; later input changes SHALL have no effect.
REQ-016 SHALL decode opcodes: 0 NOP, 1 ADD A+B, 2 SUB A-B, 3 AND, 4 OR, 5 XOR, 6 SHL A<<B[log2(WIDTH)-1:0], 7 SHR logical, same amount, 8 MUL unsigned full product {oResultHi,oResult}.
REQ-017 SHALL complete NOP and reserved opcodes 9-15 with oResult=0, oResultHi=0, oFlags=0.
REQ-018 SHALL move non-MUL ops (and MUL with FAST_MUL=1) IDLE->DONE on accept; oValid is high on the first edge after accept (latency 1).
REQ-019 SHALL move MUL with FAST_MUL=0 IDLE->BUSY and perform one shift-add step per cycle for WIDTH cycles, then go BUSY->DONE; oValid is high exactly WIDTH+1 edges after accept.
REQ-020 SHALL go DONE->IDLE on an edge with oValid&&iReady; oReady is high on that same edge's output, with no accept in the handshake cycle itself.
REQ-021 SHALL hold oResult, oResultHi and oFlags stable while oValid=1 and iReady=0, for any number of cycles.
REQ-022 SHALL ignore iValid while in BUSY or DONE (no queueing, no drop indication).
REQ-023 SHALL set Z = (oResult==0) and N = oResult[WIDTH-1], for all ops.
REQ-024 SHALL set C as follows: ADD carry-out; SUB borrow (A<B unsigned); SHL/SHR last bit shifted out, 0 when amount=0; MUL (oResultHi!=0); logic ops 0.
REQ-025 SHALL set V to two's-complement overflow for ADD/SUB and to 0 for all other ops.
REQ-026 SHALL discard ADD/SUB carry beyond WIDTH from oResult (modulo 2^WIDTH).

Reset
REQ-027 SHALL, with Reset_n low, asynchronously force state IDLE, oReady=0, oValid=0, oResult=0, oResultHi=0, oFlags=0, and clear the multiplier accumulator and counter.
REQ-028 SHALL raise oReady on the first rising edge after Reset_n deasserts.
REQ-029 SHALL abandon any op in progress (BUSY or DONE) on reset, and no oValid for it SHALL appear after release.

Verification (WIDTH=16)
REQ-030 ADD 0x7FFF+0x0001 -> oValid 1 edge after accept; oResult 0x8000, oFlags N=1 Z=0 C=0 V=1.
REQ-031 SUB 0x0003-0x0005 -> oResult 0xFFFE, N=1 Z=0 C=1 V=0; SUB 0x8000-0x0001 -> oResult 0x7FFF, V=1.
REQ-032 FAST_MUL=0, MUL 0x1234*0x0100 -> oReady=0 throughout, oValid exactly 17 edges after accept, oResultHi 0x0012, oResult 0x3400, C=1.
REQ-033 FAST_MUL=1, MUL 0xFFFF*0xFFFF -> latency 1, oResultHi 0xFFFE, oResult 0x0001, C=1.
REQ-034 Backpressure: XOR 0xAAAA^0xAAAA with iReady=0 for 5 cycles -> oResult 0x0000, Z=1, outputs stable throughout; iValid pulses during DONE ignored; oReady=1 after the handshake edge.
REQ-035 Reset_n pulsed low 8 cycles into an iterative MUL -> all outputs 0 immediately; no oValid after release; oReady=1 on the first edge after release; a following ADD 2+3 returns 0x0005.
